// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the sequential ALU:
//   - op encodings OP_ADD .. OP_SHR (3-bit opcode presented with the operands)
//   - FSM state encoding (IDLE, SHIFT, DONE)
//   - is_shift() helper used by the control logic
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Operand and result channels of the sequential ALU, each with valid/ready.
//   in_valid/in_ready : operand channel (op, a, b, cin)
//   out_valid/out_ready : result channel (result, flag_z/n/c/v)
// Modports:
//   master : operand source / result consumer (drives operands, out_ready)
//   slave  : the ALU (drives in_ready, result, flags, out_valid)
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_adder_w.sv
// -----------------------------------------------------------------------------
// alu_adder_w
// WIDTH-bit ripple-carry adder built from full-adder cells. Shared by ADD and
// SUB (the caller feeds ~b and cin=1 for subtraction).
// Ports:
//   sum  out WIDTH  a + b + cin, modulo 2^WIDTH
//   cout out 1      carry out of the MSB
//   ovf  out 1      signed overflow = carry into MSB xor carry out of MSB
//   a, b in WIDTH   addends
//   cin  in 1       carry in
// -----------------------------------------------------------------------------
module alu_adder_w #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic carry;
  logic carry_msb;

  // The carry ripples through a loop variable rather than a carry vector so the
  // chain is evaluated in one pass instead of as a self-dependent signal.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch or loop,
    // otherwise a path that skips the assignment infers a latch.
    sum       = '0;
    carry     = cin;
    carry_msb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) carry_msb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign cout = carry;
  assign ovf  = carry ^ carry_msb;

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// WIDTH-bit ALU with registered result and flags and valid/ready on both
// sides. ADD/SUB/AND/OR/XOR/NOT complete in one cycle; SHL/SHR shift one bit
// per cycle for b[SHAMT_W-1:0] cycles. One operation in flight at a time.
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave modport of alu_seq_if (operands in, result/flags out)
// -----------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t state, state_next;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic               start_shift;

  // Shift working state
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] count;
  logic               shift_left;
  logic [WIDTH-1:0]   step_val;
  logic               step_bit;
  logic               last_step;

  // Single-cycle datapath
  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_c;
  logic               imm_v;

  // Result register load
  logic               load_en;
  logic [WIDTH-1:0]   load_val;
  logic               load_c;
  logic               load_v;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  assign accept      = bus.in_valid && bus.in_ready;
  assign shamt       = bus.b[SHAMT_W-1:0];
  assign start_shift = is_shift(bus.op) && (shamt != '0);
  assign last_step   = (count == SHAMT_W'(1));

  // SUB is a + ~b + 1 on the same adder; cin only matters for ADD.
  assign b_eff   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
  assign cin_eff = (bus.op == OP_SUB) ? 1'b1 : bus.cin;

  alu_adder_w #(.WIDTH(WIDTH)) u_adder (
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .a    (bus.a),
    .b    (b_eff),
    .cin  (cin_eff)
  );

  // Result of every op that finishes on the accept edge. A zero-length shift
  // lands in the default arm: result is a, C and V are 0.
  always_comb begin
    imm_res = bus.a;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        imm_res = sum;
        imm_c   = cout;
        imm_v   = ovf;
      end
      OP_AND:  imm_res = bus.a & bus.b;
      OP_OR:   imm_res = bus.a | bus.b;
      OP_XOR:  imm_res = bus.a ^ bus.b;
      OP_NOT:  imm_res = ~bus.a;
      default: imm_res = bus.a;
    endcase
  end

  // One shift step; step_bit is the bit falling off the end.
  always_comb begin
    if (shift_left) begin
      step_val = {work[WIDTH-2:0], 1'b0};
      step_bit = work[WIDTH-1];
    end else begin
      step_val = {1'b0, work[WIDTH-1:1]};
      step_bit = work[0];
    end
  end

  // Result and flags are written exactly once, on the edge that enters DONE.
  always_comb begin
    load_en  = 1'b0;
    load_val = imm_res;
    load_c   = imm_c;
    load_v   = imm_v;
    if (state == IDLE && accept && !start_shift) begin
      load_en = 1'b1;
    end else if (state == SHIFT && last_step) begin
      load_en  = 1'b1;
      load_val = step_val;
      load_c   = step_bit;
      load_v   = 1'b0;
    end
  end

  // FSM next state; unused encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // process reads the pre-edge value regardless of evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      count      <= '0;
      shift_left <= 1'b0;
    end else if (state == IDLE && accept && start_shift) begin
      work       <= bus.a;
      count      <= shamt;
      shift_left <= (bus.op == OP_SHL);
    end else if (state == SHIFT) begin
      work  <= step_val;
      count <= count - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result <= '0;
      bus.flag_z <= 1'b0;
      bus.flag_n <= 1'b0;
      bus.flag_c <= 1'b0;
      bus.flag_v <= 1'b0;
    end else if (load_en) begin
      bus.result <= load_val;
      bus.flag_z <= (load_val == '0);
      bus.flag_n <= load_val[WIDTH-1];
      bus.flag_c <= load_c;
      bus.flag_v <= load_v;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed vector table for alu_seq (WIDTH=8) plus hand-written sequences for
// backpressure and reset during a shift.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int MAX_LAT = 20;

  logic clk;
  logic rst_n;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] flags;  // {z, n, c, v}
    int         lat;
  } vec_t;

  vec_t vecs[16];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  // Presents one operation, scrambles the inputs after accept, waits for
  // out_valid, checks latency/result/flags and the handshake back to IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int ready_seen;
    @(negedge clk);
    check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = v.op;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.cin       = v.cin;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = ~v.a;
    bus.b        = ~v.b;
    bus.op       = ~v.op;
    bus.cin      = ~v.cin;
    lat = 1;
    ready_seen = 0;
    while (!bus.out_valid && lat < MAX_LAT) begin
      if (bus.in_ready) ready_seen++;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) ready_seen++;
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " in_ready low while busy"}, 32'(ready_seen), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(v.res));
    check({tag, " flags zncv"}, 32'(dut_flags()), 32'(v.flags));
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid dropped"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    int lat;

    //              op      a      b      cin   res    zncv     lat
    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 1};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010, 1};
    vecs[2]  = '{OP_ADD, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000, 1};
    vecs[3]  = '{OP_ADD, 8'h80, 8'h80, 1'b1, 8'h01, 4'b0011, 1};
    vecs[4]  = '{OP_SUB, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1010, 1};
    vecs[5]  = '{OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0100, 1};
    vecs[6]  = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0011, 1};
    vecs[7]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 1};
    vecs[8]  = '{OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0100, 1};
    vecs[9]  = '{OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b1000, 1};
    vecs[10] = '{OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0100, 1};
    vecs[11] = '{OP_SHR, 8'h81, 8'h01, 1'b0, 8'h40, 4'b0010, 2};
    vecs[12] = '{OP_SHL, 8'h81, 8'h00, 1'b0, 8'h81, 4'b0100, 1};
    vecs[13] = '{OP_SHL, 8'h01, 8'h07, 1'b0, 8'h80, 4'b0100, 8};
    vecs[14] = '{OP_SHL, 8'h81, 8'h0A, 1'b0, 8'h04, 4'b0000, 3};
    vecs[15] = '{OP_SHL, 8'hC0, 8'h02, 1'b0, 8'h00, 4'b1010, 3};

    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset flags", 32'(dut_flags()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset release", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held, no accept while DONE waits for out_ready.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.a         = 8'h12;
    bus.b         = 8'h34;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp out_valid after accept", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus.a = 8'h50 + 8'(k);
      @(negedge clk);
      check($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp hold%0d result", k), 32'(bus.result), 32'h46);
      check($sformatf("bp hold%0d flags", k), 32'(dut_flags()), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("bp out_valid drops", 32'(bus.out_valid), 32'd0);
    check("bp in_ready returns", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("bp no stray accept", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a shift: outputs clear without a clock edge.
    bus.in_valid = 1'b1;
    bus.op       = OP_SHL;
    bus.a        = 8'h03;
    bus.b        = 8'h05;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-shift busy", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-shift reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid-shift reset result", 32'(bus.result), 32'd0);
    check("mid-shift reset flags", 32'(dut_flags()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready after mid-shift reset", 32'(bus.in_ready), 32'd1);
    v = '{OP_ADD, 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000, 1};
    run_vec(v, "post-reset add");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
